// File: rtl/prog_sequencer_pkg.sv
// Shared types and default sizing for the program run sequencer.
package prog_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StClear = 2'b01,
      StRun   = 2'b10,
      StDone  = 2'b11
   } seq_state_e;

   localparam int unsigned DefaultCw        = 16;
   localparam int unsigned DefaultMaxCycles = 16'hFFFF;

endpackage

// File: rtl/prog_sequencer_run_counter.sv
// Saturation-free up-counter with synchronous clear (priority over enable).
module prog_sequencer_run_counter #(
   parameter int unsigned CW = 16
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr_i,
   input  logic          en_i,
   output logic [CW-1:0] count_o
);

   logic [CW-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Run controller for the PC: start/clear/run/done sequencing with a cycle-budget watchdog.
module prog_sequencer
   import prog_sequencer_pkg::*;
#(
   parameter int unsigned CW         = DefaultCw,
   parameter int unsigned MAX_CYCLES = DefaultMaxCycles
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Start,
   input  logic          Halt,
   input  logic          Stall,
   input  logic          BranchReq,
   input  logic          Taken,
   output logic          PcReset,
   output logic          PcEn,
   output logic          BranchEn,
   output logic          Busy,
   output logic          Done,
   output logic          Timeout,
   output logic [CW-1:0] CycleCount,
   output logic [CW-1:0] InstrCount
);

   seq_state_e state_d, state_q;
   logic       pc_reset_q, busy_q, done_q, timeout_d, timeout_q;
   logic       in_run, retire, halt_now, wdog_hit, cnt_clr;

   always_comb begin
      in_run   = (state_q == StRun);
      retire   = in_run && !Stall;
      halt_now = retire && Halt;
      wdog_hit = in_run && (CycleCount == CW'(MAX_CYCLES - 1));
      // Counters read zero for the whole CLEAR cycle, so clear on entry.
      cnt_clr  = (state_d == StClear);

      state_d = state_q;
      unique case (state_q)
         StIdle:  if (Start) state_d = StClear;
         StClear: state_d = StRun;
         StRun:   if (halt_now || wdog_hit) state_d = StDone;
         StDone:  if (Start) state_d = StClear;
         default: state_d = StIdle;
      endcase

      // Halt beats the watchdog when both land in the same cycle.
      timeout_d = (state_d == StDone) && (in_run ? !halt_now : timeout_q);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= StIdle;
         pc_reset_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_reset_q <= (state_d == StClear);
         busy_q     <= (state_d == StClear) || (state_d == StRun);
         done_q     <= (state_d == StDone);
         timeout_q  <= timeout_d;
      end
   end

   // A halt holds the PC on its own address; a stall suppresses everything.
   assign PcEn     = in_run && !Stall && !Halt;
   assign BranchEn = PcEn && BranchReq && Taken;
   assign PcReset  = pc_reset_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign Timeout  = timeout_q;

   prog_sequencer_run_counter #(
      .CW(CW)
   ) u_cycle_cnt (
      .clk_i  (Clk),
      .rst_ni (Reset),
      .clr_i  (cnt_clr),
      .en_i   (in_run),
      .count_o(CycleCount)
   );

   prog_sequencer_run_counter #(
      .CW(CW)
   ) u_instr_cnt (
      .clk_i  (Clk),
      .rst_ni (Reset),
      .clr_i  (cnt_clr),
      .en_i   (retire),
      .count_o(InstrCount)
   );

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench: directed vector table, hand sequences and a random run vs a reference model.
module tb_prog_sequencer;
   import prog_sequencer_pkg::*;

   localparam int unsigned CW   = DefaultCw;
   localparam int unsigned MaxC = 8;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          Start = 1'b0, Halt = 1'b0, Stall = 1'b0, BranchReq = 1'b0, Taken = 1'b0;
   logic          PcReset, PcEn, BranchEn, Busy, Done, Timeout;
   logic [CW-1:0] CycleCount, InstrCount;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: phase 0 idle, 1 clear, 2 run, 3 done.
   int m_phase = 0;
   int m_cyc   = 0;
   int m_ins   = 0;
   bit m_to    = 1'b0;

   typedef struct packed {
      logic        start, halt, stall, br, tk;
      logic        pcr, pce, bre, busy, done, tmo;
      logic [15:0] cyc, ins;
   } vec_t;

   vec_t tbl [9];

   prog_sequencer #(
      .CW        (CW),
      .MAX_CYCLES(MaxC)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Start     (Start),
      .Halt      (Halt),
      .Stall     (Stall),
      .BranchReq (BranchReq),
      .Taken     (Taken),
      .PcReset   (PcReset),
      .PcEn      (PcEn),
      .BranchEn  (BranchEn),
      .Busy      (Busy),
      .Done      (Done),
      .Timeout   (Timeout),
      .CycleCount(CycleCount),
      .InstrCount(InstrCount)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_phase = 0;
      m_cyc   = 0;
      m_ins   = 0;
      m_to    = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      case (m_phase)
         0, 3: if (Start) begin
            m_phase = 1;
            m_cyc   = 0;
            m_ins   = 0;
            m_to    = 1'b0;
         end
         1: m_phase = 2;
         default: begin
            m_cyc++;
            if (!Stall) m_ins++;
            if (!Stall && Halt) begin
               m_phase = 3;
               m_to    = 1'b0;
            end else if (m_cyc == MaxC) begin
               m_phase = 3;
               m_to    = 1'b1;
            end
         end
      endcase
   endtask

   task automatic check_model(input string tag);
      logic exp_pce;
      exp_pce = (m_phase == 2) && !Stall && !Halt;
      chk({tag, ".PcReset"}, PcReset, m_phase == 1);
      chk({tag, ".PcEn"}, PcEn, exp_pce);
      chk({tag, ".BranchEn"}, BranchEn, exp_pce && BranchReq && Taken);
      chk({tag, ".Busy"}, Busy, (m_phase == 1) || (m_phase == 2));
      chk({tag, ".Done"}, Done, m_phase == 3);
      chk({tag, ".Timeout"}, Timeout, (m_phase == 3) && m_to);
      chk({tag, ".CycleCount"}, CycleCount, m_cyc);
      chk({tag, ".InstrCount"}, InstrCount, m_ins);
   endtask

   task automatic drive(input logic s, input logic h, input logic st, input logic b,
                        input logic t);
      Start     = s;
      Halt      = h;
      Stall     = st;
      BranchReq = b;
      Taken     = t;
   endtask

   // Entered at posedge+1: drive, check at negedge, clock, update model.
   task automatic cycle(input string tag, input logic s, input logic h, input logic st,
                        input logic b, input logic t);
      drive(s, h, st, b, t);
      #4;
      check_model(tag);
      @(posedge Clk);
      model_step();
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".PcReset"}, PcReset, 0);
      chk({tag, ".PcEn"}, PcEn, 0);
      chk({tag, ".BranchEn"}, BranchEn, 0);
      chk({tag, ".Busy"}, Busy, 0);
      chk({tag, ".Done"}, Done, 0);
      chk({tag, ".Timeout"}, Timeout, 0);
      chk({tag, ".CycleCount"}, CycleCount, 0);
      chk({tag, ".InstrCount"}, InstrCount, 0);
   endtask

   // Asynchronous reset pulse landing mid-cycle; entered and left at posedge+1.
   task automatic mid_cycle_reset(input string tag);
      #2;
      Reset = 1'b0;
      #1;
      check_all_zero(tag);
      model_reset();
      @(posedge Clk);
      #1;
      Reset = 1'b1;
   endtask

   initial begin
      // start,halt,stall,br,tk | pcr,pce,bre,busy,done,tmo | cyc,ins
      tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 16'd0};
      tbl[1] = '{0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0, 16'd0, 16'd0};
      tbl[2] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'd0, 16'd0};
      tbl[3] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 16'd1, 16'd1};
      tbl[4] = '{0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 16'd2, 16'd2};
      tbl[5] = '{1, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 16'd3, 16'd3};
      tbl[6] = '{0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 16'd4, 16'd4};
      tbl[7] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 16'd5, 16'd5};
      tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 16'd5, 16'd5};

      repeat (2) @(posedge Clk);
      #1;
      check_all_zero("reset");
      Reset = 1'b1;

      // Plain run, branch variants, ignored Start, halt on the 5th RUN cycle.
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].start, tbl[i].halt, tbl[i].stall, tbl[i].br, tbl[i].tk);
         #4;
         chk($sformatf("tbl%0d.PcReset", i), PcReset, tbl[i].pcr);
         chk($sformatf("tbl%0d.PcEn", i), PcEn, tbl[i].pce);
         chk($sformatf("tbl%0d.BranchEn", i), BranchEn, tbl[i].bre);
         chk($sformatf("tbl%0d.Busy", i), Busy, tbl[i].busy);
         chk($sformatf("tbl%0d.Done", i), Done, tbl[i].done);
         chk($sformatf("tbl%0d.Timeout", i), Timeout, tbl[i].tmo);
         chk($sformatf("tbl%0d.CycleCount", i), CycleCount, tbl[i].cyc);
         chk($sformatf("tbl%0d.InstrCount", i), InstrCount, tbl[i].ins);
         @(posedge Clk);
         model_step();
         #1;
      end

      // Restart from DONE with counts of 5; then stalls mid-run.
      cycle("restart", 1, 0, 0, 0, 0);
      chk("clear.PcReset", PcReset, 1);
      chk("clear.CycleCount", CycleCount, 0);
      chk("clear.InstrCount", InstrCount, 0);
      cycle("clear", 0, 0, 0, 0, 0);
      cycle("stl.r1", 0, 0, 0, 0, 0);
      cycle("stl.r2", 0, 0, 0, 0, 0);
      cycle("stl.s1", 0, 1, 1, 1, 1);
      cycle("stl.s2", 0, 0, 1, 1, 1);
      cycle("stl.s3", 0, 1, 1, 0, 0);
      cycle("stl.r3", 0, 0, 0, 1, 1);
      cycle("stl.halt", 0, 1, 0, 0, 0);
      chk("stall.Done", Done, 1);
      chk("stall.Timeout", Timeout, 0);
      chk("stall.CycleCount", CycleCount, 7);
      chk("stall.InstrCount", InstrCount, 4);

      // Watchdog expiry, then halt landing on the last budgeted cycle.
      cycle("wd.start", 1, 0, 0, 0, 0);
      cycle("wd.clear", 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) cycle("wd.run", 0, 0, 0, 0, 0);
      chk("wd.Done", Done, 1);
      chk("wd.Timeout", Timeout, 1);
      chk("wd.CycleCount", CycleCount, 8);
      chk("wd.InstrCount", InstrCount, 8);
      cycle("wd.hold", 0, 0, 0, 1, 1);
      chk("wd.held.Timeout", Timeout, 1);

      cycle("wh.start", 1, 0, 0, 0, 0);
      chk("wh.clear.Timeout", Timeout, 0);
      cycle("wh.clear", 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) cycle("wh.run", 0, 0, 0, 0, 0);
      cycle("wh.halt", 0, 1, 0, 0, 0);
      chk("wh.Done", Done, 1);
      chk("wh.Timeout", Timeout, 0);
      chk("wh.CycleCount", CycleCount, 8);
      chk("wh.InstrCount", InstrCount, 8);

      // Asynchronous reset in the middle of a RUN cycle.
      cycle("ar.start", 1, 0, 0, 0, 0);
      cycle("ar.clear", 0, 0, 0, 0, 0);
      cycle("ar.r1", 0, 0, 0, 0, 0);
      cycle("ar.r2", 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 1);
      mid_cycle_reset("async");
      cycle("ar.idle", 0, 0, 0, 0, 0);

      // Random traffic against the model, with occasional asynchronous resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            mid_cycle_reset("rnd.areset");
         end else begin
            cycle("rnd", $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
